// File: rtl/seq_stack_unit.sv
`default_nettype none
// =============================================================================
// seq_stack_unit : program sequencer (PC + next-PC decode) with hardware return stack
// Revision 1.0
// =============================================================================
module seq_stack_unit #(
  parameter int              PC_W        = 11,
  parameter int              STACK_DEPTH = 2,
  parameter int              OVF_WRAP    = 1,
  parameter logic [PC_W-1:0] RST_VEC     = {PC_W{1'b1}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [11:0]     instr,
  input  logic            z,
  input  logic            pcl_wr,
  input  logic [7:0]      f_in_data,
  input  logic [PC_W-9:0] pa,
  output logic [PC_W-1:0] pc,
  output logic [7:0]      pcl1,
  output logic [4:0]      stk_lvl,
  output logic            stk_ovf,
  output logic            stk_unf
);

  localparam int              PA_W    = PC_W - 8;
  localparam int              SP_W    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_LAST = SP_W'(STACK_DEPTH - 1);
  localparam logic [4:0]      LVL_MAX = 5'(STACK_DEPTH);
  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
  localparam logic [PC_W-1:0] PC_TWO  = PC_W'(2);
  localparam logic            WRAP_EN = (OVF_WRAP != 0);

  logic [PC_W-1:0] r_pc;
  logic [SP_W-1:0] r_sp;
  logic [4:0]      r_lvl;
  logic            r_ovf;
  logic            r_unf;
  logic [PC_W-1:0] r_mem [STACK_DEPTH];

  logic [PC_W-1:0] w_pc1;
  logic [PC_W-1:0] w_pc2;
  logic [SP_W-1:0] w_sp_inc;
  logic [SP_W-1:0] w_sp_dec;
  logic            w_full;
  logic            w_empty;
  logic            w_goto;
  logic            w_call;
  logic            w_ret;
  logic            w_skip;
  logic            w_push_wr;
  logic            w_unused_pa0;

  assign w_pc1    = r_pc + PC_ONE;
  assign w_pc2    = r_pc + PC_TWO;
  assign w_sp_inc = (r_sp == SP_LAST) ? '0 : r_sp + 1'b1;
  assign w_sp_dec = (r_sp == '0) ? SP_LAST : r_sp - 1'b1;
  assign w_full   = (r_lvl == LVL_MAX);
  assign w_empty  = (r_lvl == 5'd0);

  assign w_goto = (instr[11:9] == 3'b101);
  assign w_call = (instr[11:8] == 4'b1001);
  assign w_ret  = (instr[11:8] == 4'b1000);
  assign w_skip = ((instr[11:8] == 4'b0111) && !z) ||
                  ((instr[11:8] == 4'b0110) &&  z) ||
                  ((instr[11:6] == 6'b001111) && z) ||
                  ((instr[11:6] == 6'b001011) && z);

  // Only the upper page bits select the page; pa[0] has no role in addressing.
  assign w_unused_pa0 = pa[0];

  // A full non-wrapping stack drops the push entirely, so memory stays untouched.
  assign w_push_wr = !rst && !stall && w_call && (!w_full || WRAP_EN);

  always_ff @(posedge clk) begin
    if (w_push_wr) begin
      r_mem[r_sp] <= w_pc1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= RST_VEC;
      r_sp  <= '0;
      r_lvl <= 5'd0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (!stall) begin
      if (w_goto) begin
        r_pc <= {pa[PA_W-1:1], instr[8:0]};
      end else if (w_call) begin
        r_pc <= {pa[PA_W-1:1], 1'b0, instr[7:0]};
        if (!w_full) begin
          r_sp  <= w_sp_inc;
          r_lvl <= r_lvl + 5'd1;
        end else begin
          r_ovf <= 1'b1;
          if (WRAP_EN) begin
            r_sp <= w_sp_inc;
          end
        end
      end else if (w_ret) begin
        if (!w_empty) begin
          r_pc  <= r_mem[w_sp_dec];
          r_sp  <= w_sp_dec;
          r_lvl <= r_lvl - 5'd1;
        end else begin
          r_pc  <= RST_VEC;
          r_unf <= 1'b1;
        end
      end else if (w_skip) begin
        r_pc <= w_pc2;
      end else if (pcl_wr) begin
        r_pc <= {pa[PA_W-1:1], 1'b0, f_in_data};
      end else begin
        r_pc <= w_pc1;
      end
    end
  end

  assign pc      = r_pc;
  assign pcl1    = w_pc1[7:0];
  assign stk_lvl = r_lvl;
  assign stk_ovf = r_ovf;
  assign stk_unf = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_seq_stack_unit.sv
`default_nettype none
// =============================================================================
// tb_seq_stack_unit : directed self-checking bench, wrapping and non-wrapping stacks
// Revision 1.0
// =============================================================================
module tb_seq_stack_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [11:0] instr;
  logic        z;
  logic        pcl_wr;
  logic [7:0]  f_in_data;
  logic [2:0]  pa;

  logic [10:0] pc_w,  pc_d;
  logic [7:0]  pcl1_w, pcl1_d;
  logic [4:0]  lvl_w, lvl_d;
  logic        ovf_w, ovf_d, unf_w, unf_d;

  int tests;
  int fails;

  localparam logic [11:0] NOP    = 12'h000;
  localparam logic [11:0] RETLW  = 12'h800;
  localparam logic [11:0] BTFSS  = 12'h700;
  localparam logic [11:0] BTFSC  = 12'h600;
  localparam logic [11:0] DECFSZ = 12'h2C0;
  localparam logic [11:0] INCFSZ = 12'h3C0;
  localparam logic [11:0] DECF   = 12'h280;

  seq_stack_unit #(.PC_W(11), .STACK_DEPTH(2), .OVF_WRAP(1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .instr(instr), .z(z), .pcl_wr(pcl_wr),
    .f_in_data(f_in_data), .pa(pa), .pc(pc_w), .pcl1(pcl1_w), .stk_lvl(lvl_w),
    .stk_ovf(ovf_w), .stk_unf(unf_w)
  );

  seq_stack_unit #(.PC_W(11), .STACK_DEPTH(2), .OVF_WRAP(0)) dut_drop (
    .clk(clk), .rst(rst), .stall(stall), .instr(instr), .z(z), .pcl_wr(pcl_wr),
    .f_in_data(f_in_data), .pa(pa), .pc(pc_d), .pcl1(pcl1_d), .stk_lvl(lvl_d),
    .stk_ovf(ovf_d), .stk_unf(unf_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; instr = NOP; z = 1'b0; pcl_wr = 1'b0; f_in_data = 8'h00; pa = 3'b000;
    tick(); tick();
    tests++; if (pc_w !== 11'h7FF) begin fails++; $display("FAIL reset_pc got=%h exp=7ff", pc_w); end
    tests++; if (lvl_w !== 5'd0) begin fails++; $display("FAIL reset_lvl got=%0d exp=0", lvl_w); end
    tests++; if ({ovf_w, unf_w, ovf_d, unf_d} !== 4'b0000) begin fails++; $display("FAIL reset_flags got=%b exp=0000", {ovf_w, unf_w, ovf_d, unf_d}); end
    tests++; if (pcl1_w !== 8'h00) begin fails++; $display("FAIL reset_pcl1 got=%h exp=00", pcl1_w); end
    rst = 1'b0;
    tick();
    tests++; if (pc_w !== 11'h000) begin fails++; $display("FAIL reset_wrap_pc got=%h exp=000", pc_w); end
  endtask

  task automatic test_jumps();
    pa = 3'b101; instr = 12'hBA5;
    tick();
    tests++; if (pc_w !== 11'h5A5) begin fails++; $display("FAIL goto_pc got=%h exp=5a5", pc_w); end
    instr = NOP; pcl_wr = 1'b1; f_in_data = 8'h3C;
    tick();
    tests++; if (pc_w !== 11'h43C) begin fails++; $display("FAIL pclwr_pc got=%h exp=43c", pc_w); end
    pcl_wr = 1'b0; instr = 12'h920;
    tick();
    tests++; if (pc_w !== 11'h420) begin fails++; $display("FAIL call_page_pc got=%h exp=420", pc_w); end
    tests++; if (lvl_w !== 5'd1) begin fails++; $display("FAIL call_page_lvl got=%0d exp=1", lvl_w); end
    instr = RETLW;
    tick();
    tests++; if (pc_w !== 11'h43D) begin fails++; $display("FAIL call_page_ret got=%h exp=43d", pc_w); end
  endtask

  task automatic test_call_ret();
    pa = 3'b000; instr = 12'hA10;
    tick();
    instr = 12'h920;
    tick();
    tests++; if (pc_w !== 11'h020 || lvl_w !== 5'd1) begin fails++; $display("FAIL nest_call1 got pc=%h lvl=%0d exp pc=020 lvl=1", pc_w, lvl_w); end
    instr = 12'h930;
    tick();
    tests++; if (pc_w !== 11'h030 || lvl_w !== 5'd2) begin fails++; $display("FAIL nest_call2 got pc=%h lvl=%0d exp pc=030 lvl=2", pc_w, lvl_w); end
    instr = RETLW;
    tick();
    tests++; if (pc_w !== 11'h021 || lvl_w !== 5'd1) begin fails++; $display("FAIL nest_ret1 got pc=%h lvl=%0d exp pc=021 lvl=1", pc_w, lvl_w); end
    tick();
    tests++; if (pc_w !== 11'h011 || lvl_w !== 5'd0) begin fails++; $display("FAIL nest_ret2 got pc=%h lvl=%0d exp pc=011 lvl=0", pc_w, lvl_w); end
    tests++; if (pcl1_w !== 8'h12) begin fails++; $display("FAIL nest_pcl1 got=%h exp=12", pcl1_w); end
    tests++; if ({ovf_w, unf_w} !== 2'b00) begin fails++; $display("FAIL nest_flags got=%b exp=00", {ovf_w, unf_w}); end
  endtask

  task automatic test_overflow();
    instr = 12'hB00;
    tick();
    instr = 12'h910;
    tick();
    instr = 12'h920;
    tick();
    tests++; if ({ovf_w, ovf_d} !== 2'b00 || lvl_w !== 5'd2) begin fails++; $display("FAIL ovf_fill got ovf=%b lvl=%0d exp ovf=00 lvl=2", {ovf_w, ovf_d}, lvl_w); end
    instr = 12'h930;
    tick();
    tests++; if (pc_w !== 11'h030 || pc_d !== 11'h030) begin fails++; $display("FAIL ovf_pc got=%h/%h exp=030/030", pc_w, pc_d); end
    tests++; if ({ovf_w, ovf_d} !== 2'b11) begin fails++; $display("FAIL ovf_flag got=%b exp=11", {ovf_w, ovf_d}); end
    tests++; if (lvl_w !== 5'd2 || lvl_d !== 5'd2) begin fails++; $display("FAIL ovf_lvl got=%0d/%0d exp=2/2", lvl_w, lvl_d); end
    instr = RETLW;
    tick();
    tests++; if (pc_w !== 11'h021 || pc_d !== 11'h011) begin fails++; $display("FAIL ovf_ret1 got=%h/%h exp=021/011", pc_w, pc_d); end
    tick();
    tests++; if (pc_w !== 11'h011 || pc_d !== 11'h101) begin fails++; $display("FAIL ovf_ret2 got=%h/%h exp=011/101", pc_w, pc_d); end
    tests++; if ({unf_w, unf_d} !== 2'b00) begin fails++; $display("FAIL unf_early got=%b exp=00", {unf_w, unf_d}); end
    tick();
    tests++; if (pc_w !== 11'h7FF || pc_d !== 11'h7FF) begin fails++; $display("FAIL unf_pc got=%h/%h exp=7ff/7ff", pc_w, pc_d); end
    tests++; if ({unf_w, unf_d, ovf_w} !== 3'b111 || lvl_w !== 5'd0) begin fails++; $display("FAIL unf_flags got=%b lvl=%0d exp=111 lvl=0", {unf_w, unf_d, ovf_w}, lvl_w); end
  endtask

  task automatic test_skip();
    instr = BTFSS; z = 1'b0;
    tick();
    tests++; if (pc_w !== 11'h001) begin fails++; $display("FAIL btfss_skip got=%h exp=001", pc_w); end
    pa = 3'b110; instr = 12'hBFF;
    tick();
    instr = BTFSS; z = 1'b1;
    tick();
    tests++; if (pc_w !== 11'h000) begin fails++; $display("FAIL btfss_noskip got=%h exp=000", pc_w); end
    instr = DECFSZ; z = 1'b1;
    tick();
    tests++; if (pc_w !== 11'h002) begin fails++; $display("FAIL decfsz_skip got=%h exp=002", pc_w); end
    z = 1'b0;
    tick();
    tests++; if (pc_w !== 11'h003) begin fails++; $display("FAIL decfsz_noskip got=%h exp=003", pc_w); end
    instr = BTFSC; z = 1'b1;
    tick();
    tests++; if (pc_w !== 11'h005) begin fails++; $display("FAIL btfsc_skip got=%h exp=005", pc_w); end
    instr = INCFSZ;
    tick();
    tests++; if (pc_w !== 11'h007) begin fails++; $display("FAIL incfsz_skip got=%h exp=007", pc_w); end
    instr = DECF;
    tick();
    tests++; if (pc_w !== 11'h008) begin fails++; $display("FAIL decf_noskip got=%h exp=008", pc_w); end
    z = 1'b0; pcl_wr = 1'b1; f_in_data = 8'h77; instr = NOP;
    tick();
    tests++; if (pc_w !== 11'h677) begin fails++; $display("FAIL pclwr_page got=%h exp=677", pc_w); end
    pcl_wr = 1'b0; pa = 3'b000;
  endtask

  task automatic test_stall();
    stall = 1'b1; instr = 12'h940;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (pc_w !== 11'h677 || lvl_w !== 5'd0) begin fails++; $display("FAIL stall_hold%0d got pc=%h lvl=%0d exp pc=677 lvl=0", i, pc_w, lvl_w); end
    end
    stall = 1'b0;
    tick();
    tests++; if (pc_w !== 11'h040 || lvl_w !== 5'd1) begin fails++; $display("FAIL stall_release got pc=%h lvl=%0d exp pc=040 lvl=1", pc_w, lvl_w); end
    instr = NOP;
    tick();
    tests++; if (pc_w !== 11'h041 || lvl_w !== 5'd1) begin fails++; $display("FAIL stall_single_push got pc=%h lvl=%0d exp pc=041 lvl=1", pc_w, lvl_w); end
    stall = 1'b1; instr = 12'h950; rst = 1'b1;
    tick();
    tests++; if (pc_w !== 11'h7FF || lvl_w !== 5'd0) begin fails++; $display("FAIL stall_rst got pc=%h lvl=%0d exp pc=7ff lvl=0", pc_w, lvl_w); end
    tests++; if ({ovf_w, unf_w, ovf_d, unf_d} !== 4'b0000) begin fails++; $display("FAIL stall_rst_flags got=%b exp=0000", {ovf_w, unf_w, ovf_d, unf_d}); end
    rst = 1'b0; stall = 1'b0; instr = RETLW;
    tick();
    tests++; if (pc_w !== 11'h7FF || unf_w !== 1'b1) begin fails++; $display("FAIL post_rst_unf got pc=%h unf=%b exp pc=7ff unf=1", pc_w, unf_w); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_jumps();
    test_call_ret();
    test_overflow();
    test_skip();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
